hs_spi_avmm_arbiter: RTL and testbench
======================================

HS_SPI_AVMM_ARBITER -- requirements
Module: hs_spi_avmm_arbiter

Interface
REQ-001 Parameter AW, default 10, AVMM address width.
REQ-002 Parameter DW, default 32, AVMM data width; byteenable width is DW/8.
REQ-003 Parameter TIMEOUT, default 1024, maximum cycles to wait for read data before an error completion.
REQ-004 Port aclk  in  1  single clock for all logic.
REQ-005 Port aresetn  in  1  asynchronous, active-low reset.
REQ-006 Port s{0,1}_address  in  AW  requester word address.
REQ-007 Port s{0,1}_write / s{0,1}_read  in  1 each  requester write / read request.
REQ-008 Port s{0,1}_writedata  in  DW; s{0,1}_byteenable  in  DW/8.
REQ-009 Port s{0,1}_waitrequest  out  1  request not accepted this cycle.
REQ-010 Port s{0,1}_readdata  out  DW; s{0,1}_readdatavalid  out  1.
REQ-011 Port s{0,1}_rderr  out  1  pulses with readdatavalid on a timed-out read.
REQ-012 Port m_address  out  AW; m_write, m_read  out  1; m_writedata  out  DW; m_byteenable  out  DW/8; all drive the HS SPI master's AVMM slave.
REQ-013 Port m_waitrequest  in  1; m_readdata  in  DW; m_readdatavalid  in  1.
REQ-014 Port grant  out  1  index of the requester owning the current or last transaction.
REQ-015 Port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states: IDLE, CMD, RDWAIT; at most one transaction outstanding on the m_ side.
REQ-017 IDLE, a port is requesting when its read or write is high; one requester -> that port is granted.
REQ-018 IDLE, both requesting -> round-robin: grant the port not equal to last_grant.
REQ-019 Grant cycle: granted s_waitrequest low for exactly that cycle; address, writedata, byteenable and direction captured into registers; last_grant and grant updated; next state CMD.
REQ-020 Port with read and write both high is accepted as a write; read is not consumed.
REQ-021 Non-granted port, and every port outside the grant cycle, sees s_waitrequest = 1.
REQ-022 CMD: m_* driven only from the captured registers; m_write or m_read held high until m_waitrequest is sampled low.
REQ-023 CMD, accepted write -> IDLE; accepted read -> RDWAIT with timeout counter cleared.
REQ-024 Latency: m_write/m_read asserts one cycle after the s-side grant cycle.
REQ-025 RDWAIT: m_read low; on m_readdatavalid, readdata forwarded combinationally to the granted port, its readdatavalid pulses one cycle, next state IDLE.
REQ-026 RDWAIT: counter reaching TIMEOUT-1 without m_readdatavalid -> granted port readdatavalid=1, rderr=1, readdata = 0xDEADBEEF for one cycle, state IDLE.
REQ-027 m_readdatavalid outside RDWAIT is ignored; no s-side readdatavalid is produced.
REQ-028 s{0,1}_readdata shows m_readdata at all times except during a timeout completion; readdatavalid/rderr assert only on the granted port.
REQ-029 IDLE is always entered for at least one cycle between transactions; a new grant is never made in CMD or RDWAIT.

Reset
REQ-030 aresetn low asynchronously forces IDLE, last_grant=1 (port 0 wins first tie), grant=0, busy=0, counter=0.
REQ-031 During reset: s_waitrequest=1, s_readdatavalid=0, s_rderr=0, m_write=0, m_read=0, m_address/writedata/byteenable=0.
REQ-032 Reset asserted in CMD or RDWAIT abandons the transaction; no readdatavalid is later produced for it.

Verification
REQ-033 s0 write addr 0x004 data 0x12345678, m_waitrequest low -> s0_waitrequest low 1 cycle, m_write with same values next cycle, busy low after.
REQ-034 s0 and s1 reads in same cycle after reset -> s0 granted first, then s1; alternation repeats over 4 back-to-back pairs.
REQ-035 s1 read, m_waitrequest high 3 cycles, m_readdata 0xCAFEF00D 2 cycles after acceptance -> m_read held 4 cycles, s1_readdatavalid 1 cycle with 0xCAFEF00D, s0 none.
REQ-036 Read with no m_readdatavalid, TIMEOUT=16 -> after 16 RDWAIT cycles rderr=1, readdata 0xDEADBEEF, FSM IDLE.
REQ-037 aresetn low during RDWAIT, late m_readdatavalid after release -> no s-side readdatavalid, all outputs at reset values.

Source files
------------

// File: rtl/hs_spi_avmm_arbiter_if.sv
// rtl/hs_spi_avmm_arbiter_if.sv - AVMM bus bundle used for both requester ports and the HS SPI side
//
// Signals
//   address, write, read, writedata, byteenable : command, issued by the master side
//   waitrequest, readdata, readdatavalid         : response, returned by the slave side
//   rderr                                         : pulses with readdatavalid when a read timed out
//                                                   (only the requester ports use it)
// Modports
//   slave  : the receiving end of a command (the arbiter's requester ports)
//   master : the issuing end of a command (the arbiter's HS SPI port)
interface hs_spi_avmm_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic            write;
    logic            read;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            rderr;

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata, readdatavalid, rderr
    );

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/hs_spi_avmm_arbiter.sv
// rtl/hs_spi_avmm_arbiter.sv - two-requester round-robin AVMM arbiter in front of an HS SPI master
//
// Ports
//   aclk, aresetn : clock and asynchronous active-low reset
//   s0, s1        : requester AVMM ports (slave modport); s0/s1 waitrequest is low only
//                   in the cycle the port is granted
//   m             : AVMM port to the HS SPI master's register slave (master modport)
//   grant         : index of the requester owning the current or most recent transaction
//   busy          : high while a transaction is in flight (FSM not idle)
//
// At most one transaction is outstanding on the m side. Reads that see no
// m.readdatavalid within TIMEOUT cycles complete with rderr and 0xDEADBEEF.
module hs_spi_avmm_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    hs_spi_avmm_arbiter_if.slave   s0,
    hs_spi_avmm_arbiter_if.slave   s1,
    hs_spi_avmm_arbiter_if.master  m,
    output logic                   grant,
    output logic                   busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RDWAIT
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              grant_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   be_q;
    logic              m_write_q;
    logic              m_read_q;
    logic [CW-1:0]     cnt_q;

    logic              req0;
    logic              req1;
    logic              take_d;
    logic              sel_d;
    logic [AW-1:0]     addr_d;
    logic [DW-1:0]     wdata_d;
    logic [DW/8-1:0]   be_d;
    logic              is_write_d;
    logic              rd_done;
    logic              rd_tmo;
    logic              cpl;

    // Arbitration: a lone requester wins outright; on a tie the port that did
    // not win last time is picked. Gating with aresetn keeps waitrequest high
    // while reset is held even though the state register already reads idle.
    always_comb begin
        req0       = s0.read | s0.write;
        req1       = s1.read | s1.write;
        take_d     = aresetn && (state_q == ST_IDLE) && (req0 || req1);
        sel_d      = (req0 && req1) ? ~last_grant_q : req1;
        addr_d     = sel_d ? s1.address    : s0.address;
        wdata_d    = sel_d ? s1.writedata  : s0.writedata;
        be_d       = sel_d ? s1.byteenable : s0.byteenable;
        // write wins when a port raises read and write together
        is_write_d = sel_d ? s1.write      : s0.write;
    end

    // Read completion: real data has priority over a timeout hitting the same cycle.
    always_comb begin
        rd_done = (state_q == ST_RDWAIT) && m.readdatavalid;
        rd_tmo  = (state_q == ST_RDWAIT) && !m.readdatavalid && (cnt_q == CNT_LAST);
        cpl     = rd_done || rd_tmo;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            m_write_q    <= 1'b0;
            m_read_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_d) begin
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        be_q         <= be_d;
                        m_write_q    <= is_write_d;
                        m_read_q     <= !is_write_d;
                        last_grant_q <= sel_d;
                        grant_q      <= sel_d;
                        state_q      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!m.waitrequest) begin
                        m_write_q <= 1'b0;
                        m_read_q  <= 1'b0;
                        if (m_write_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (cpl) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s0.waitrequest   = !(take_d && !sel_d);
    assign s1.waitrequest   = !(take_d && sel_d);

    assign s0.readdata      = rd_tmo ? ERR_DATA : m.readdata;
    assign s1.readdata      = rd_tmo ? ERR_DATA : m.readdata;
    assign s0.readdatavalid = cpl && !grant_q;
    assign s1.readdatavalid = cpl && grant_q;
    assign s0.rderr         = rd_tmo && !grant_q;
    assign s1.rderr         = rd_tmo && grant_q;

    assign m.address        = addr_q;
    assign m.writedata      = wdata_q;
    assign m.byteenable     = be_q;
    assign m.write          = m_write_q;
    assign m.read           = m_read_q;

    assign grant            = grant_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_spi_avmm_arbiter.sv
// tb/tb_hs_spi_avmm_arbiter.sv - self-checking bench for hs_spi_avmm_arbiter
module tb_hs_spi_avmm_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic aclk;
    logic aresetn;
    logic grant;
    logic busy;

    hs_spi_avmm_arbiter_if #(.AW(AW), .DW(DW)) s0_if ();
    hs_spi_avmm_arbiter_if #(.AW(AW), .DW(DW)) s1_if ();
    hs_spi_avmm_arbiter_if #(.AW(AW), .DW(DW)) m_if ();

    hs_spi_avmm_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .grant   (grant),
        .busy    (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: is a transaction open, has the HS SPI side
    // taken its command, who owns it, and how long a read has been waiting.
    bit              md_active = 0;
    bit              md_acc    = 0;
    bit              md_wr     = 0;
    bit              md_win    = 0;
    bit              md_last   = 1;
    bit              md_grant  = 0;
    logic [AW-1:0]   md_addr   = '0;
    logic [DW-1:0]   md_wdata  = '0;
    logic [DW/8-1:0] md_be     = '0;
    int              md_waits  = 0;

    always @(negedge aclk) begin : compare
        logic [1:0]  e_wait;
        logic [1:0]  e_rdv;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        logic        e_mw;
        logic        e_mr;
        logic        e_busy;
        logic        e_grant;
        logic        r0;
        logic        r1;
        logic        w;
        e_wait  = 2'b11;
        e_rdv   = 2'b00;
        e_err   = 2'b00;
        e_rdata = m_if.readdata;
        e_mw    = 1'b0;
        e_mr    = 1'b0;
        e_busy  = 1'b0;
        e_grant = md_grant;
        if (!aresetn) begin
            e_grant = 1'b0;
            chk("rst_m_address", m_if.address, 0);
            chk("rst_m_writedata", m_if.writedata, 0);
            chk("rst_m_byteenable", m_if.byteenable, 0);
            md_active = 0;
            md_last   = 1;
            md_grant  = 0;
        end else if (!md_active) begin
            r0 = s0_if.read | s0_if.write;
            r1 = s1_if.read | s1_if.write;
            if (r0 || r1) begin
                w = (r0 && r1) ? !md_last : r1;
                e_wait[w] = 1'b0;
                md_wr     = w ? s1_if.write      : s0_if.write;
                md_addr   = w ? s1_if.address    : s0_if.address;
                md_wdata  = w ? s1_if.writedata  : s0_if.writedata;
                md_be     = w ? s1_if.byteenable : s0_if.byteenable;
                md_win    = w;
                md_last   = w;
                md_grant  = w;
                md_active = 1;
                md_acc    = 0;
            end
        end else if (!md_acc) begin
            e_busy = 1'b1;
            e_mw   = md_wr;
            e_mr   = !md_wr;
            chk("cmd_m_address", m_if.address, md_addr);
            chk("cmd_m_writedata", m_if.writedata, md_wdata);
            chk("cmd_m_byteenable", m_if.byteenable, md_be);
            if (!m_if.waitrequest) begin
                if (md_wr) begin
                    md_active = 0;
                end else begin
                    md_acc   = 1;
                    md_waits = 0;
                end
            end
        end else begin
            e_busy = 1'b1;
            if (m_if.readdatavalid) begin
                e_rdv[md_win] = 1'b1;
                md_active = 0;
            end else if (md_waits == TO - 1) begin
                e_rdv[md_win] = 1'b1;
                e_err[md_win] = 1'b1;
                e_rdata = 32'hDEADBEEF;
                md_active = 0;
            end else begin
                md_waits++;
            end
        end
        chk("s0_waitrequest", s0_if.waitrequest, e_wait[0]);
        chk("s1_waitrequest", s1_if.waitrequest, e_wait[1]);
        chk("s0_readdatavalid", s0_if.readdatavalid, e_rdv[0]);
        chk("s1_readdatavalid", s1_if.readdatavalid, e_rdv[1]);
        chk("s0_rderr", s0_if.rderr, e_err[0]);
        chk("s1_rderr", s1_if.rderr, e_err[1]);
        chk("s0_readdata", s0_if.readdata, e_rdata);
        chk("s1_readdata", s1_if.readdata, e_rdata);
        chk("m_write", m_if.write, e_mw);
        chk("m_read", m_if.read, e_mr);
        chk("busy", busy, e_busy);
        chk("grant", grant, e_grant);
    end

    task automatic clear_req(input int p);
        if (p == 0) begin
            s0_if.read = 0; s0_if.write = 0;
        end else begin
            s1_if.read = 0; s1_if.write = 0;
        end
    endtask

    task automatic new_req(input int p);
        int          k;
        logic        rd;
        logic        wr;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [DW/8-1:0] b;
        k  = $urandom_range(0, 7);
        rd = (k == 4) || (k == 5) || (k == 7);
        wr = (k == 6) || (k == 7);
        a  = AW'($urandom);
        d  = $urandom;
        b  = (DW/8)'($urandom);
        if (p == 0) begin
            s0_if.read = rd; s0_if.write = wr; s0_if.address = a;
            s0_if.writedata = d; s0_if.byteenable = b;
        end else begin
            s1_if.read = rd; s1_if.write = wr; s1_if.address = a;
            s1_if.writedata = d; s1_if.byteenable = b;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (busy && n < 50);
        chk("wait_idle_bound", busy, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] seq [$];
        int          n;
        bit          acc0;
        bit          acc1;

        aresetn = 0;
        s0_if.read = 0; s0_if.write = 0; s0_if.address = '0; s0_if.writedata = '0; s0_if.byteenable = '0;
        s1_if.read = 0; s1_if.write = 0; s1_if.address = '0; s1_if.writedata = '0; s1_if.byteenable = '0;
        m_if.waitrequest = 1; m_if.readdata = 32'h0BAD_0BAD; m_if.readdatavalid = 0; m_if.rderr = 0;

        // Requests raised while reset is held must not be granted.
        s0_if.read = 1; s1_if.write = 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s0_waitrequest", s0_if.waitrequest, 1);
        chk("rst_s1_waitrequest", s1_if.waitrequest, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m_read", m_if.read, 0);

        // Tied reads straight out of reset: s0 first, then strict alternation.
        @(posedge aclk); #1;
        aresetn = 1;
        s0_if.read = 1; s0_if.write = 0; s1_if.read = 1; s1_if.write = 0;
        m_if.waitrequest = 0; m_if.readdatavalid = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge aclk);
            if (!s0_if.waitrequest) seq.push_back(0);
            if (!s1_if.waitrequest) seq.push_back(1);
        end
        @(posedge aclk); #1;
        clear_req(0); clear_req(1); m_if.readdatavalid = 0;
        chk("rr_grant_count", seq.size(), 8);
        for (int i = 0; i < 8 && i < seq.size(); i++) chk("rr_order", seq[i], i % 2);
        wait_idle();

        // Single write from s0.
        @(posedge aclk); #1;
        s0_if.write = 1; s0_if.address = 10'h004; s0_if.writedata = 32'h12345678; s0_if.byteenable = 4'hF;
        m_if.waitrequest = 0;
        @(negedge aclk);
        chk("wr_s0_granted", s0_if.waitrequest, 0);
        chk("wr_s1_not_granted", s1_if.waitrequest, 1);
        @(posedge aclk); #1;
        clear_req(0);
        @(negedge aclk);
        chk("wr_m_write", m_if.write, 1);
        chk("wr_m_address", m_if.address, 10'h004);
        chk("wr_m_writedata", m_if.writedata, 32'h12345678);
        chk("wr_m_byteenable", m_if.byteenable, 4'hF);
        @(negedge aclk);
        chk("wr_busy_after", busy, 0);

        // s1 read, HS SPI stalls 3 cycles, data 2 cycles after acceptance.
        @(posedge aclk); #1;
        s1_if.read = 1; s1_if.address = 10'h3F0;
        m_if.waitrequest = 1;
        @(negedge aclk);
        chk("rd_s1_granted", s1_if.waitrequest, 0);
        @(posedge aclk); #1;
        clear_req(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("rd_m_read_held", m_if.read, 1);
            @(posedge aclk); #1;
            m_if.waitrequest = (i == 2) ? 1'b0 : 1'b1;
        end
        @(negedge aclk);
        chk("rd_m_read_dropped", m_if.read, 0);
        chk("rd_s1_no_early_rdv", s1_if.readdatavalid, 0);
        @(posedge aclk); #1;
        m_if.readdatavalid = 1; m_if.readdata = 32'hCAFEF00D;
        @(negedge aclk);
        chk("rd_s1_rdv", s1_if.readdatavalid, 1);
        chk("rd_s1_data", s1_if.readdata, 32'hCAFEF00D);
        chk("rd_s0_no_rdv", s0_if.readdatavalid, 0);
        @(posedge aclk); #1;
        m_if.readdatavalid = 0;
        @(negedge aclk);
        chk("rd_s1_rdv_one_cycle", s1_if.readdatavalid, 0);
        chk("rd_busy_after", busy, 0);

        // Read that never gets data: times out after TO waiting cycles.
        @(posedge aclk); #1;
        s0_if.read = 1; m_if.waitrequest = 0;
        @(negedge aclk);
        chk("to_s0_granted", s0_if.waitrequest, 0);
        @(posedge aclk); #1;
        clear_req(0);
        @(negedge aclk);
        chk("to_m_read", m_if.read, 1);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!s0_if.readdatavalid && n < 40);
        chk("to_wait_cycles", n, TO);
        chk("to_rderr", s0_if.rderr, 1);
        chk("to_data", s0_if.readdata, 32'hDEADBEEF);
        chk("to_s1_no_rdv", s1_if.readdatavalid, 0);
        @(negedge aclk);
        chk("to_busy_after", busy, 0);

        // Reset during a pending read abandons it; late data is ignored.
        @(posedge aclk); #1;
        s0_if.read = 1;
        @(negedge aclk);
        chk("rr_s0_granted", s0_if.waitrequest, 0);
        @(posedge aclk); #1;
        clear_req(0);
        @(negedge aclk);
        @(negedge aclk);
        chk("rr_busy_in_rdwait", busy, 1);
        @(posedge aclk); #1;
        aresetn = 0;
        @(negedge aclk);
        chk("rr_busy_reset", busy, 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1;
        m_if.readdatavalid = 1; m_if.readdata = 32'h5555AAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("rr_s0_no_late_rdv", s0_if.readdatavalid, 0);
            chk("rr_s1_no_late_rdv", s1_if.readdatavalid, 0);
            chk("rr_m_read_idle", m_if.read, 0);
            chk("rr_grant_reset", grant, 0);
        end
        @(posedge aclk); #1;
        m_if.readdatavalid = 0;

        // Randomized traffic; the compare process checks every cycle.
        acc0 = 1; acc1 = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge aclk); #1;
            if (acc0 || !(s0_if.read || s0_if.write)) begin
                if ($urandom_range(0, 1) == 0) new_req(0); else clear_req(0);
            end
            if (acc1 || !(s1_if.read || s1_if.write)) begin
                if ($urandom_range(0, 1) == 0) new_req(1); else clear_req(1);
            end
            m_if.waitrequest   = ($urandom_range(0, 2) == 0);
            // a quiet window forces timeouts; elsewhere data arrives sporadically
            m_if.readdatavalid = (c >= 1500 && c < 2200) ? 1'b0 : ($urandom_range(0, 5) == 0);
            m_if.readdata      = $urandom;
            if (c == 3000) aresetn = 0;
            if (c == 3003) aresetn = 1;
            @(negedge aclk);
            acc0 = (s0_if.read || s0_if.write) && !s0_if.waitrequest;
            acc1 = (s1_if.read || s1_if.write) && !s1_if.waitrequest;
        end
        @(posedge aclk); #1;
        clear_req(0); clear_req(1); m_if.readdatavalid = 0; m_if.waitrequest = 0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
